// File: rtl/inst_pkg.sv
// inst_pkg: format/error codes, FSM states and field bundle shared by the encoder blocks
package inst_pkg;
  localparam int ADDR_W = 10;
  localparam logic [2:0] FMT_SHIFT = 3'd0, FMT_IMM16 = 3'd1, FMT_SPLIT16 = 3'd2, FMT_BRANCH = 3'd3, FMT_JUMP = 3'd4;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_RANGE = 2'd1, ERR_ALIGN = 2'd2, ERR_FMT = 2'd3;
  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ERR} state_t;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } fields_t;
  // true when imm[31:lo] are all equal, i.e. the value fits as a signed field
  function automatic logic all_eq(input logic [31:0] v, input logic [4:0] lo);
    logic [31:0] m;
    m = '1 << lo;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction
endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field handshake and instruction-memory write port
interface inst_encoder_if;
  import inst_pkg::*;
  logic [5:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [5:0]        in_funct;
  logic [2:0]        in_fmt;
  logic [31:0]       in_imm;
  logic              in_valid, in_ready;
  logic              mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (output in_op, in_rs, in_rt, in_rd, in_funct, in_fmt, in_imm, in_valid, mem_ready,
                  input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_op, in_rs, in_rt, in_rd, in_funct, in_fmt, in_imm, in_valid, mem_ready,
                 output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_pack.sv
// inst_pack: packs instruction fields into a 32-bit word and flags range/alignment/format errors
module inst_pack
  import inst_pkg::*;
(
  input  fields_t     i_f,
  output logic [31:0] o_word,
  output logic [1:0]  o_code
);
  always_comb begin
    o_word = '0;
    o_code = ERR_NONE;
    case (i_f.fmt)
      FMT_SHIFT: begin
        o_word = {i_f.op, i_f.rs, i_f.rt, i_f.rd, i_f.imm[4:0], i_f.funct};
        o_code = |i_f.imm[31:5] ? ERR_RANGE : ERR_NONE;
      end
      FMT_IMM16: begin
        o_word = {i_f.op, i_f.rs, i_f.rt, i_f.imm[15:0]};
        o_code = all_eq(i_f.imm, 5'd15) ? ERR_NONE : ERR_RANGE;
      end
      FMT_SPLIT16: begin
        o_word = {i_f.op, i_f.rs, i_f.imm[15:11], i_f.rd, i_f.imm[10:0]};
        o_code = all_eq(i_f.imm, 5'd15) ? ERR_NONE : ERR_RANGE;
      end
      FMT_BRANCH: begin
        o_word = {i_f.op, i_f.rs, i_f.rt, i_f.imm[17:2]};
        o_code = |i_f.imm[1:0] ? ERR_ALIGN : all_eq(i_f.imm, 5'd17) ? ERR_NONE : ERR_RANGE;
      end
      FMT_JUMP: begin
        o_word = {i_f.op, i_f.imm[27:2]};
        o_code = |i_f.imm[1:0] ? ERR_ALIGN : all_eq(i_f.imm, 5'd27) ? ERR_NONE : ERR_RANGE;
      end
      default: o_code = ERR_FMT;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts instruction fields, encodes them and writes words to instruction memory
module inst_encoder
  import inst_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              err_clr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              wrap,
  output logic [10:0]       wcount,
  inst_encoder_if.slave     io
);
  state_t            r_state, w_next;
  fields_t           r_hold;
  logic              r_live, r_err, r_wrap, w_xfer;
  logic [1:0]        r_code, w_code;
  logic [10:0]       r_wcount;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, w_word;
  inst_pack u_pack (.i_f(r_hold), .o_word(w_word), .o_code(w_code));
  assign err          = r_err;
  assign err_code     = r_code;
  assign wrap         = r_wrap;
  assign wcount       = r_wcount;
  assign io.mem_addr  = r_addr;
  assign io.mem_wdata = r_wdata;
  assign w_xfer       = io.in_ready && io.in_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // r_live keeps in_ready low until the first clock edge after reset releases
  always_comb begin
    w_next      = r_state;
    io.in_ready = r_live && r_state == IDLE && !cfg_load;
    io.mem_we   = r_state == WRITE;
    case (r_state)
      IDLE:    w_next = w_xfer ? ENCODE : IDLE;
      ENCODE:  w_next = w_code == ERR_NONE ? WRITE : ERR;
      WRITE:   w_next = io.mem_ready ? IDLE : WRITE;
      ERR:     w_next = err_clr ? IDLE : ERR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_hold   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wcount <= '0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
      r_wrap   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_xfer) r_hold <= {io.in_op, io.in_rs, io.in_rt, io.in_rd, io.in_funct, io.in_fmt, io.in_imm};
      if (r_state == IDLE && cfg_load) begin
        r_addr   <= cfg_base;
        r_wcount <= '0;
        r_wrap   <= 1'b0;
      end
      if (r_state == ENCODE && w_code == ERR_NONE) r_wdata <= w_word;
      if (r_state == ENCODE && w_code != ERR_NONE) begin
        r_err  <= 1'b1;
        r_code <= w_code;
      end
      if (io.mem_we && io.mem_ready) begin
        r_addr   <= r_addr + 1'b1;
        r_wrap   <= r_wrap | (&r_addr);
        r_wcount <= r_wcount + {10'd0, ~&r_wcount};
      end
      if (r_state == ERR && err_clr) begin
        r_err  <= 1'b0;
        r_code <= ERR_NONE;
        r_wrap <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vectors with hand-computed words against inst_encoder
module tb_inst_encoder;
  import inst_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b1, cfg_load = 1'b0, err_clr = 1'b0;
  logic [9:0]  cfg_base = '0;
  logic        err, wrap;
  logic [1:0]  err_code;
  logic [10:0] wcount;
  int          total = 0, bad = 0;
  inst_encoder_if io();
  inst_encoder dut (.clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_base(cfg_base), .err_clr(err_clr),
                    .err(err), .err_code(err_code), .wrap(wrap), .wcount(wcount), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [9:0] base);
    cfg_load = 1'b1;
    cfg_base = base;
    tick();
    cfg_load = 1'b0;
  endtask
  task automatic clr;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", {31'd0, err}, 0);
    chk("clr_code", {30'd0, err_code}, 0);
  endtask
  task automatic send(input logic [2:0] fmt, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [31:0] imm);
    int n = 0;
    while (!io.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready", {31'd0, io.in_ready}, 1);
    io.in_fmt = fmt; io.in_op = op; io.in_rs = rs; io.in_rt = rt;
    io.in_rd = rd; io.in_funct = funct; io.in_imm = imm;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    chk("encode_no_we", {31'd0, io.mem_we}, 0);
    tick();
  endtask
  task automatic wr(input string tag, input logic [9:0] a, input logic [31:0] d, input int stall);
    chk({tag, "_we"}, {31'd0, io.mem_we}, 1);
    chk({tag, "_addr"}, {22'd0, io.mem_addr}, {22'd0, a});
    chk({tag, "_data"}, io.mem_wdata, d);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_we"}, {31'd0, io.mem_we}, 1);
      chk({tag, "_hold_addr"}, {22'd0, io.mem_addr}, {22'd0, a});
      chk({tag, "_hold_data"}, io.mem_wdata, d);
    end
    io.mem_ready = 1'b1;
    tick();
    io.mem_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, io.mem_we}, 0);
  endtask
  task automatic bad_word(input string tag, input logic [1:0] code);
    chk({tag, "_no_we"}, {31'd0, io.mem_we}, 0);
    chk({tag, "_err"}, {31'd0, err}, 1);
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, code});
    tick();
    chk({tag, "_stay_no_we"}, {31'd0, io.mem_we}, 0);
    chk({tag, "_stay_busy"}, {31'd0, io.in_ready}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    io.in_valid = 1'b0; io.mem_ready = 1'b0;
    io.in_fmt = '0; io.in_op = '0; io.in_rs = '0; io.in_rt = '0;
    io.in_rd = '0; io.in_funct = '0; io.in_imm = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", {31'd0, io.mem_we}, 0);
    chk("rst_ready", {31'd0, io.in_ready}, 0);
    chk("rst_addr", {22'd0, io.mem_addr}, 0);
    chk("rst_wdata", io.mem_wdata, 0);
    chk("rst_wcount", {21'd0, wcount}, 0);
    chk("rst_err", {29'd0, err, err_code}, 0);
    chk("rst_wrap", {31'd0, wrap}, 0);
    #11 rst_n = 1'b1;
    chk("ready_before_edge", {31'd0, io.in_ready}, 0);
    tick();
    chk("ready_after_edge", {31'd0, io.in_ready}, 1);
    cfg(10'h010);
    send(FMT_IMM16, 6'h23, 5'd29, 5'd8, 5'd0, 6'd0, 32'hFFFFFFFC);
    wr("imm16", 10'h010, 32'h8FA8FFFC, 0);
    chk("wcount1", {21'd0, wcount}, 1);
    send(FMT_BRANCH, 6'h05, 5'd1, 5'd2, 5'd0, 6'd0, 32'hFFFFFFF8);
    wr("branch", 10'h011, 32'h1422FFFE, 3);
    send(FMT_JUMP, 6'h02, 5'd0, 5'd0, 5'd0, 6'd0, 32'h00000100);
    wr("jump", 10'h012, 32'h08000040, 0);
    chk("wcount3", {21'd0, wcount}, 3);
    send(FMT_SHIFT, 6'h00, 5'd0, 5'd9, 5'd10, 6'd0, 32'h4);
    wr("shift", 10'h013, 32'h00095100, 0);
    send(FMT_SHIFT, 6'h00, 5'd0, 5'd9, 5'd10, 6'd0, 32'h20);
    bad_word("shift_rng", ERR_RANGE);
    clr();
    chk("wcount_after_err", {21'd0, wcount}, 4);
    send(FMT_BRANCH, 6'h05, 5'd1, 5'd2, 5'd0, 6'd0, 32'h6);
    bad_word("br_align", ERR_ALIGN);
    clr();
    send(3'b101, 6'h01, 5'd1, 5'd1, 5'd1, 6'd1, 32'h0);
    bad_word("bad_fmt", ERR_FMT);
    cfg(10'h200);
    chk("cfg_in_err_err", {31'd0, err}, 1);
    chk("cfg_in_err_addr", {22'd0, io.mem_addr}, 32'h014);
    clr();
    chk("cfg_in_err_wcount", {21'd0, wcount}, 4);
    send(FMT_IMM16, 6'h00, 5'd0, 5'd0, 5'd0, 6'd0, 32'h00008000);
    bad_word("imm16_rng", ERR_RANGE);
    clr();
    send(FMT_SPLIT16, 6'h0F, 5'd3, 5'd0, 5'd7, 6'd0, 32'h00001234);
    wr("split16", 10'h014, 32'h3C623A34, 0);
    io.in_valid = 1'b1;
    cfg_load = 1'b1;
    cfg_base = 10'h100;
    #1;
    chk("cfg_prio_ready", {31'd0, io.in_ready}, 0);
    tick();
    cfg_load = 1'b0;
    io.in_valid = 1'b0;
    chk("cfg_prio_addr", {22'd0, io.mem_addr}, 32'h100);
    chk("cfg_prio_wcount", {21'd0, wcount}, 0);
    tick();
    tick();
    chk("cfg_prio_no_we", {31'd0, io.mem_we}, 0);
    cfg(10'h3FF);
    send(FMT_IMM16, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 32'h5);
    wr("wrap_a", 10'h3FF, 32'h20220005, 0);
    chk("wrap_set", {31'd0, wrap}, 1);
    send(FMT_IMM16, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 32'h6);
    wr("wrap_b", 10'h000, 32'h20220006, 0);
    chk("wrap_wcount", {21'd0, wcount}, 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_idle_wrap", {31'd0, wrap}, 1);
    send(3'b111, 6'h00, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0);
    bad_word("fmt7", ERR_FMT);
    clr();
    chk("clr_wrap", {31'd0, wrap}, 0);
    chk("clr_addr", {22'd0, io.mem_addr}, 32'h001);
    send(FMT_IMM16, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 32'h7);
    chk("mid_we", {31'd0, io.mem_we}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, io.mem_we}, 0);
    chk("mid_rst_addr", {22'd0, io.mem_addr}, 0);
    chk("mid_rst_wdata", io.mem_wdata, 0);
    chk("mid_rst_wcount", {21'd0, wcount}, 0);
    chk("mid_rst_ready", {31'd0, io.in_ready}, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, io.in_ready}, 0);
    tick();
    chk("mid_rel_ready2", {31'd0, io.in_ready}, 1);
    chk("mid_rel_we", {31'd0, io.mem_we}, 0);
    chk("mid_rel_wcount", {21'd0, wcount}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cfg_load in 1 and cfg_base in 10, which load the write address.
REQ-004 SHALL have the field inputs in_op 6, in_rs 5, in_rt 5, in_rd 5, in_funct 6, in_fmt 3 and in_imm 32. in_imm is the sign-extended immediate value, shifted where the format requires.
REQ-005 SHALL have: in_valid in 1 and in_ready out 1, forming the field handshake.
REQ-006 SHALL have: mem_we out 1, mem_addr out 10, mem_wdata out 32 and mem_ready in 1, forming the instruction-memory write port.
REQ-007 SHALL have: err out 1 (sticky), err_code out 2, err_clr in 1, wrap out 1 (sticky) and wcount out 11 (words written).

Function
REQ-008 SHALL use these in_fmt codes: 000 SHIFT, 001 IMM16, 010 SPLIT16, 011 BRANCH, 100 JUMP; codes 101-111 are invalid.
REQ-009 SHALL pack each format as follows:
- SHIFT: {op, rs, rt, rd, imm[4:0], funct}
- IMM16: {op, rs, rt, imm[15:0]}
- SPLIT16: {op, rs, imm[15:11], rd, imm[10:0]}
- BRANCH: {op, rs, rt, imm[17:2]}
- JUMP: {op, imm[27:2]}
REQ-010 SHALL apply these range rules:
- SHIFT: imm[31:5] is zero.
- IMM16 and SPLIT16: imm[31:15] bits are all equal.
- BRANCH: imm[1:0]=0 and imm[31:17] bits are all equal.
- JUMP: imm[1:0]=0 and imm[31:27] bits are all equal.
REQ-011 SHALL set err_code as 11 for an invalid fmt, 10 for misalignment and 01 for out of range. The priority is 11 > 10 > 01.
REQ-012 SHALL implement the FSM states IDLE, ENCODE, WRITE and ERR.
REQ-013 SHALL drive in_ready=1 only in IDLE with cfg_load=0. A transfer occurs when in_valid and in_ready are both 1, and the fields are captured into a holding register.
REQ-014 SHALL sequence a transfer as follows:
- Transfer at cycle N: the FSM is in ENCODE at N+1.
- At N+1 the word and range result are registered.
- At N+2 the FSM is in WRITE with mem_we=1, or in ERR.
REQ-015 SHALL hold mem_we, mem_addr and mem_wdata stable until mem_ready=1. On mem_we&mem_ready: mem_addr+1, wcount+1, return to IDLE.
REQ-016 SHALL wrap mem_addr from 0x3FF to 0x000 and set wrap; writing continues.
REQ-017 SHALL saturate wcount at 0x7FF.
REQ-018 SHALL, in ERR: issue no write, set err=1, latch err_code, keep in_ready=0.
REQ-019 SHALL make err_clr effective only in ERR: next state IDLE, err, err_code and wrap cleared, mem_addr unchanged.
REQ-020 SHALL accept cfg_load only in IDLE: mem_addr←cfg_base, wcount←0, wrap←0. In any other state it is ignored.
REQ-021 SHALL give cfg_load priority over a simultaneous in_valid in IDLE, with no transfer in that cycle.
REQ-022 SHALL give a failed word no address and leave wcount unchanged.

Reset
REQ-023 SHALL, on rst_n=0 (asynchronous, including mid-write), reset:
- FSM to IDLE, mem_we=0, in_ready=0.
- mem_addr=0, mem_wdata=0, wcount=0.
- err=0, err_code=00, wrap=0.
- The holding register to 0.
The pending word is discarded.
REQ-024 SHALL assert in_ready no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-025 SHALL take from the shared package inst_pkg: the FMT_* codes, ERR_* codes, FSM state encoding, and ADDR_W=10. The imm block uses the same format codes.
REQ-026 SHALL place packing and range checks in the combinational sub-module inst_pack (fields in, word+err_code out). inst_encoder holds the FSM, holding register and counters.

Verification
REQ-027 SHALL cover: cfg_base=0x010, IMM16 op=0x23 rs=29 rt=8 imm=0xFFFFFFFC -> mem_we at N+2, addr 0x010, wdata 0x8FA8FFFC, wcount=1.
REQ-028 SHALL cover: BRANCH op=0x05 rs=1 rt=2 imm=0xFFFFFFF8, then JUMP op=0x02 imm=0x00000100, with mem_ready held low 3 cycles -> wdata 0x1422FFFE held stable, then 0x08000040 at next address.
REQ-029 SHALL cover: SHIFT op=0 rt=9 rd=10 imm=4 funct=0 -> 0x00095100; with imm=0x20 instead -> err=1, err_code=01, no mem_we.
REQ-030 SHALL cover: BRANCH imm=0x00000006 -> err_code=10; fmt=101 -> err_code=11; with cfg_load during ERR ignored, err_clr -> IDLE, addr unchanged.
REQ-031 SHALL cover: cfg_base=0x3FF, two valid words -> addrs 0x3FF then 0x000, wrap=1.
REQ-032 SHALL cover: rst_n low while in WRITE -> mem_we drops without waiting for a clock edge, outputs at reset values, no write completes.
